data_make_sched: RTL



---
 rtl/data_make_sched_if.sv | 32 +++
 rtl/data_make_sched.sv | 118 +++++++++++
 2 files changed

// File: rtl/data_make_sched_if.sv
// rtl/data_make_sched_if.sv - capture/info requests and builder/sender handshakes of the scheduler
interface data_make_sched_if #(
  parameter int SLOT_NUM = 6
);
  logic                cap_done;
  logic [3:0]          cap_idx;
  logic                info_req;
  logic                make_fs;
  logic                make_fd;
  logic [3:0]          make_btype;
  logic [3:0]          make_idx;
  logic                send_fs;
  logic                send_fd;
  logic [3:0]          send_btype;
  logic [3:0]          send_idx;
  logic [SLOT_NUM-1:0] pend;
  logic                busy;
  logic                ovf;
  logic                tmo;

  modport master (
    input  cap_done, cap_idx, info_req, make_fd, send_fd,
    output make_fs, make_btype, make_idx, send_fs, send_btype, send_idx,
    output pend, busy, ovf, tmo
  );

  modport slave (
    output cap_done, cap_idx, info_req, make_fd, send_fd,
    input  make_fs, make_btype, make_idx, send_fs, send_btype, send_idx,
    input  pend, busy, ovf, tmo
  );
endinterface

// File: rtl/data_make_sched.sv
// rtl/data_make_sched.sv - one-job-at-a-time scheduler of frame builder and USB sender
// Round-robin over filled capture slots, INFO frames take priority.
module data_make_sched #(
  parameter int          SLOT_NUM    = 6,
  parameter logic [15:0] INFO_PERIOD = 16'd50000,
  parameter logic [15:0] TIMEOUT     = 16'hFFFF
) (
  input logic               clk,
  input logic               rst_n,
  data_make_sched_if.master bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PICK = 3'd1;
  localparam logic [2:0] MAKE = 3'd2;
  localparam logic [2:0] MREL = 3'd3;
  localparam logic [2:0] SEND = 3'd4;
  localparam logic [2:0] SREL = 3'd5;

  localparam logic [3:0] BT_INFO = 4'h1;
  localparam logic [3:0] BT_DATA = 4'hE;
  localparam logic [SLOT_NUM-1:0] ONE = {{(SLOT_NUM-1){1'b0}}, 1'b1};

  logic [2:0]          state, state_nxt;
  logic [15:0]         timer, wait_cnt;
  logic [SLOT_NUM-1:0] pend, clr_mask, set_mask;
  logic [3:0]          last, sel_idx, btype, idx;
  logic                info_pend, ovf, tmo, make_fs, send_fs;
  logic                sel_found, picking, waiting, tmr_exp, wait_exp;
  logic                cap_ok, cap_ovf, tmo_set;
  int                  j;

  assign picking  = (state == PICK);
  assign waiting  = (state == MAKE) || (state == MREL) || (state == SEND) || (state == SREL);
  assign tmr_exp  = (INFO_PERIOD != 16'd0) && (timer == INFO_PERIOD - 16'd1);
  assign wait_exp = waiting && (wait_cnt == TIMEOUT - 16'd1);
  assign cap_ok   = bus.cap_done && (int'(bus.cap_idx) < SLOT_NUM);
  assign set_mask = cap_ok ? (ONE << bus.cap_idx) : '0;
  assign clr_mask = (picking && !info_pend) ? (ONE << sel_idx) : '0;
  // A set landing on the bit PICK is clearing in the same cycle is not a loss.
  assign cap_ovf  = bus.cap_done && (!cap_ok || (|(pend & set_mask & ~clr_mask)));

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 4'd0;
    j         = 0;
    for (int k = 1; k <= SLOT_NUM; k++) begin
      j = int'(last) + k;
      if (j >= SLOT_NUM) j = j - SLOT_NUM;
      if (!sel_found && (|(pend & (ONE << j)))) begin
        sel_found = 1'b1;
        sel_idx   = j[3:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tmo_set   = 1'b0;
    if (wait_exp) begin
      state_nxt = IDLE;
      tmo_set   = 1'b1;
    end else begin
      case (state)
        IDLE:    if (info_pend || (|pend)) state_nxt = PICK;
        PICK:    state_nxt = MAKE;
        MAKE:    if (bus.make_fd) state_nxt = MREL;
        MREL:    if (!bus.make_fd) state_nxt = SEND;
        SEND:    if (bus.send_fd) state_nxt = SREL;
        SREL:    if (!bus.send_fd) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= 16'd0;
      wait_cnt  <= 16'd0;
      pend      <= '0;
      info_pend <= 1'b0;
      last      <= 4'(SLOT_NUM - 1);
      btype     <= 4'h0;
      idx       <= 4'h0;
      make_fs   <= 1'b0;
      send_fs   <= 1'b0;
      ovf       <= 1'b0;
      tmo       <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state_nxt != state || !waiting) ? 16'd0 : wait_cnt + 16'd1;
      if (INFO_PERIOD == 16'd0 || tmr_exp) timer <= 16'd0;
      else                                 timer <= timer + 16'd1;
      pend      <= (pend & ~clr_mask) | set_mask;
      info_pend <= (info_pend && !picking) || bus.info_req || tmr_exp;
      if (picking) begin
        btype <= info_pend ? BT_INFO : BT_DATA;
        idx   <= info_pend ? 4'd0 : sel_idx;
        if (!info_pend) last <= sel_idx;
      end
      make_fs <= (state_nxt == MAKE);
      send_fs <= (state_nxt == SEND);
      ovf     <= ovf || cap_ovf;
      tmo     <= tmo || tmo_set;
    end
  end

  assign bus.make_fs    = make_fs;
  assign bus.make_btype = btype;
  assign bus.make_idx   = idx;
  assign bus.send_fs    = send_fs;
  assign bus.send_btype = btype;
  assign bus.send_idx   = idx;
  assign bus.pend       = pend;
  assign bus.busy       = (state != IDLE);
  assign bus.ovf        = ovf;
  assign bus.tmo        = tmo;
endmodule
